// File: rtl/octree_bfs_pkg.sv
// Constants, branch-entry layout and FSM state encoding shared by the octree
// BFS serializer/decoder blocks.
package octree_bfs_pkg;

  localparam int BRANCH_WIDTH = 152;
  localparam int BURST_SIZE   = 64;
  localparam int ADDR_SIZE    = 9;
  localparam int CHILD_W      = 16;
  localparam int TAIL_W       = 24;
  localparam int CHILD_VEC_W  = 8 * CHILD_W;

  localparam logic [15:0] ROOT_ADDR = 16'd2;
  localparam logic [15:0] LEAF_MARK = 16'd1;
  localparam logic [15:0] NULL_ADDR = 16'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DONE
  } state_t;

  // LSB of child field c inside a full branch entry.
  function automatic int child_lsb(input int c);
    return TAIL_W + CHILD_W * c;
  endfunction

endpackage

// File: rtl/bfs_child_alloc.sv
// Combinational child allocation for one occupancy code: children are numbered
// from next_free in bit-7-first order, or all point at the leaf marker.
module bfs_child_alloc
  import octree_bfs_pkg::*;
(
  input  logic [7:0]             code,
  input  logic [15:0]            next_free,
  input  logic                   leaf,
  output logic [CHILD_VEC_W-1:0] children,
  output logic [3:0]             pop
);

  always_comb begin
    logic [3:0] above;
    children = '0;
    above    = 4'd0;
    for (int c = 7; c >= 0; c--) begin
      if (code[c]) begin
        children[child_lsb(c) - TAIL_W +: CHILD_W] =
          leaf ? LEAF_MARK : (next_free + {12'd0, above});
        above = above + 4'd1;
      end
    end
    pop = above;
  end

endmodule

// File: rtl/bfs_occ_decoder.sv
// Rebuilds the octree branch table from a BFS occupancy-code stream.
// Optional BFS_DEC_ERR_CHECK_EN adds o_err (zero code at branch level / address overflow).
// States: IDLE idle | FETCH wait for a burst word | DECODE one code per cycle | DONE finished
module bfs_occ_decoder
  import octree_bfs_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [3:0]              i_depth,
  input  logic [BURST_SIZE-1:0]   i_occ_word,
  input  logic                    i_occ_valid,
  output logic                    o_occ_ready,
  output logic [BRANCH_WIDTH-1:0] o_dinb,
  output logic [ADDR_SIZE-1:0]    o_addrb,
  output logic                    o_we_b,
  output logic [15:0]             o_branch_count,
  output logic                    o_busy,
  output logic                    o_done
`ifdef BFS_DEC_ERR_CHECK_EN
  ,
  output logic                    o_err
`endif
);

  localparam logic [16:0] MAX_FREE = 17'((1 << ADDR_SIZE) - 1);

  state_t                 state;
  logic [3:0]             depth_q;
  logic [3:0]             level;
  logic [ADDR_SIZE-1:0]   cur_addr;
  logic [15:0]            next_free;
  logic [15:0]            nodes_left;
  logic [15:0]            next_cnt;
  logic [2:0]             byte_idx;
  logic [BURST_SIZE-1:0]  word_q;

  logic [7:0]             code;
  logic                   leaf;
  logic [CHILD_VEC_W-1:0] children;
  logic [3:0]             pop;
  logic [15:0]            next_sum;
  logic                   last_node;
  logic                   finish;
  logic                   overflow;

  // ~byte_idx == 7-byte_idx, so byte 0 is the top byte of the word.
  assign code      = word_q[{~byte_idx, 3'b000} +: 8];
  assign leaf      = (level == depth_q - 4'd1);
  assign next_sum  = next_cnt + {12'd0, pop};
  assign last_node = (nodes_left == 16'd1);
  assign finish    = last_node && (((level + 4'd1) == depth_q) || (next_sum == 16'd0));

`ifdef BFS_DEC_ERR_CHECK_EN
  assign overflow = !leaf && (({1'b0, next_free} + {13'd0, pop}) > MAX_FREE);
`else
  assign overflow = 1'b0;
`endif

  bfs_child_alloc u_child_alloc (
    .code      (code),
    .next_free (next_free),
    .leaf      (leaf),
    .children  (children),
    .pop       (pop)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      depth_q        <= 4'd0;
      level          <= 4'd0;
      cur_addr       <= ADDR_SIZE'(ROOT_ADDR);
      next_free      <= ROOT_ADDR + 16'd1;
      nodes_left     <= 16'd1;
      next_cnt       <= 16'd0;
      byte_idx       <= 3'd0;
      word_q         <= '0;
      o_occ_ready    <= 1'b0;
      o_dinb         <= '0;
      o_addrb        <= '0;
      o_we_b         <= 1'b0;
      o_branch_count <= 16'd0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef BFS_DEC_ERR_CHECK_EN
      o_err          <= 1'b0;
`endif
    end else begin
      o_we_b <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            depth_q        <= i_depth;
            level          <= 4'd0;
            cur_addr       <= ADDR_SIZE'(ROOT_ADDR);
            next_free      <= ROOT_ADDR + 16'd1;
            nodes_left     <= 16'd1;
            next_cnt       <= 16'd0;
            byte_idx       <= 3'd0;
            o_branch_count <= 16'd0;
            o_done         <= 1'b0;
`ifdef BFS_DEC_ERR_CHECK_EN
            o_err          <= 1'b0;
`endif
            if (i_depth == 4'd0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state       <= ST_FETCH;
              o_occ_ready <= 1'b1;
              o_busy      <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (i_occ_valid) begin
            word_q      <= i_occ_word;
            byte_idx    <= 3'd0;
            o_occ_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (overflow) begin
            // Failing entry is dropped; the table is left as written so far.
`ifdef BFS_DEC_ERR_CHECK_EN
            o_err  <= 1'b1;
`endif
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
`ifdef BFS_DEC_ERR_CHECK_EN
            if (!leaf && code == 8'd0) o_err <= 1'b1;
`endif
            o_we_b         <= 1'b1;
            o_addrb        <= cur_addr;
            o_dinb         <= {children, {TAIL_W{1'b0}}};
            cur_addr       <= cur_addr + ADDR_SIZE'(1);
            o_branch_count <= o_branch_count + 16'd1;
            if (!leaf) next_free <= next_free + {12'd0, pop};

            if (last_node) begin
              level      <= level + 4'd1;
              nodes_left <= next_sum;
              next_cnt   <= 16'd0;
            end else begin
              nodes_left <= nodes_left - 16'd1;
              next_cnt   <= next_sum;
            end

            if (finish) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else if (byte_idx == 3'd7) begin
              state       <= ST_FETCH;
              o_occ_ready <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
